count_event_monitor: RTL
========================

COUNT_EVENT_MONITOR -- requirements
Module: count_event_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning width of monitored count bus.
REQ-002 SHALL have parameter TOT_W, default 8, meaning width of wrap total counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port clear_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port count  input  WIDTH  value from upstream counter, sampled every cycle.
REQ-006 SHALL have port enable  input  1  arms event capture when high.
REQ-007 SHALL have port threshold  input  WIDTH  compare value for hit detection.
REQ-008 SHALL have port irq_ack  input  1  acknowledge of pending irq, single-cycle or level.
REQ-009 SHALL have port wrap_pulse  output  1  one-cycle pulse on wrap.
REQ-010 SHALL have port restart_pulse  output  1  one-cycle pulse on non-wrap return to 0.
REQ-011 SHALL have port irq  output  1  high while FSM in PENDING.
REQ-012 SHALL have port status  output  3  {overrun, hit, wrap} captured flags.
REQ-013 SHALL have port wrap_total  output  TOT_W  saturating count of wraps.

Function
REQ-014 SHALL register count into count_q each cycle and set sample_vld one cycle after reset release; no event SHALL be detected while sample_vld is 0.
REQ-015 wrap SHALL be sample_vld & count_q == 2^WIDTH-1 & count == 0.
REQ-016 restart SHALL be sample_vld & count_q not in {0, 2^WIDTH-1} & count == 0.
REQ-017 hit SHALL be sample_vld & count == threshold & count_q != threshold.
REQ-018 wrap_pulse and restart_pulse SHALL be registered: asserted exactly the cycle after the detecting sample, one cycle wide.
REQ-019 wrap_total SHALL increment on each wrap regardless of enable/FSM, saturating at 2^TOT_W-1.
REQ-020 FSM states SHALL be IDLE, ARMED, PENDING.
REQ-021 IDLE -> ARMED when enable=1; ARMED -> IDLE when enable=0 and no event that cycle.
REQ-022 ARMED -> PENDING on wrap or hit in the same cycle; status.wrap/status.hit SHALL capture the causing event(s); both set if simultaneous.
REQ-023 In PENDING, further wrap/hit SHALL set status.overrun and OR into wrap/hit flags; irq stays high.
REQ-024 PENDING with irq_ack=1 SHALL clear status and go to ARMED if enable=1 else IDLE; an event coinciding with ack SHALL be lost only to status, i.e. re-enter PENDING next cycle with that event flagged.
REQ-025 enable dropping in PENDING SHALL NOT clear irq; only irq_ack leaves PENDING.
REQ-026 irq_ack outside PENDING SHALL be ignored.
REQ-027 threshold changes SHALL take effect the next sampled cycle; no hit fires from a threshold change alone.

Reset
REQ-028 clear_n=0 SHALL asynchronously force FSM=IDLE, count_q=0, sample_vld=0, wrap_pulse=0, restart_pulse=0, irq=0, status=0, wrap_total=0.
REQ-029 Reset asserted mid-PENDING SHALL drop irq immediately, without waiting for a clock edge.

Structure
REQ-030 Package count_mon_pkg SHALL hold the state enum type, default WIDTH, default TOT_W, and status bit index constants.
REQ-031 Sub-module count_transition_detect SHALL hold count_q, sample_vld and wrap/restart/hit combinational detection; the top holds FSM, status, wrap_total and output registers.

Verification
REQ-032 Free-running 4-bit count 0..15,0 with enable=1, threshold=9: hit at count 9 -> irq=1, status=3'b010; wrap at 15->0 -> wrap_pulse one cycle, status=3'b011 with overrun=1 (3'b111).
REQ-033 Count 0..6 then upstream clear to 0 -> restart_pulse=1 one cycle, wrap_pulse=0, wrap_total unchanged.
REQ-034 300 wraps with enable=0 -> wrap_total saturates at 255, irq never asserts.
REQ-035 irq pending, irq_ack=1 in the same cycle as hit (count 8->9, threshold=9) -> irq stays or returns high next cycle, status=3'b010.
REQ-036 clear_n pulsed low between clock edges while irq=1 -> irq and status go 0 immediately; first sample after release (count=0 after 15) does not report wrap.
REQ-037 threshold=0, count 15->0 -> status=3'b011 set in a single transition, overrun=0.

Source files
------------

// File: rtl/count_mon_pkg.sv
// Shared types and constants for the count event monitor: FSM state encoding,
// parameter defaults and bit positions inside the status word.
package count_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_PENDING = 2'd2
    } mon_state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_TOT_W = 8;

    localparam int STAT_WRAP_BIT = 0;
    localparam int STAT_HIT_BIT  = 1;
    localparam int STAT_OVR_BIT  = 2;

    function automatic logic [2:0] pack_status(input logic ovr, input logic hit, input logic wrap);
        logic [2:0] s;
        s = '0;
        s[STAT_OVR_BIT]  = ovr;
        s[STAT_HIT_BIT]  = hit;
        s[STAT_WRAP_BIT] = wrap;
        return s;
    endfunction

endpackage

// File: rtl/count_transition_detect.sv
// Samples the upstream count and flags wrap, restart and threshold-hit
// transitions between the previous and current sample.
module count_transition_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             clear_n_i,
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] threshold_i,
    output logic             wrap_o,
    output logic             restart_o,
    output logic             hit_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] count_q;
    logic             sample_vld_q;

    always_ff @(posedge clk_i or negedge clear_n_i) begin
        if (!clear_n_i) begin
            count_q      <= '0;
            sample_vld_q <= 1'b0;
        end else begin
            count_q      <= count_i;
            sample_vld_q <= 1'b1;
        end
    end

    // count_q is meaningless until one real sample has been taken after reset
    assign wrap_o    = sample_vld_q && (count_q == CNT_MAX) && (count_i == '0);
    assign restart_o = sample_vld_q && (count_q != '0) && (count_q != CNT_MAX) && (count_i == '0);
    assign hit_o     = sample_vld_q && (count_i == threshold_i) && (count_q != threshold_i);

endmodule

// File: rtl/count_event_monitor.sv
// Event monitor for a free-running counter: pulses on wrap/restart, counts
// wraps, and raises a latched irq with status flags until acknowledged.
module count_event_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TOT_W = DEF_TOT_W
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] count,
    input  logic             enable,
    input  logic [WIDTH-1:0] threshold,
    input  logic             irq_ack,
    output logic             wrap_pulse,
    output logic             restart_pulse,
    output logic             irq,
    output logic [2:0]       status,
    output logic [TOT_W-1:0] wrap_total
);

    logic wrap_det;
    logic restart_det;
    logic hit_det;
    logic event_det;

    count_transition_detect #(
        .WIDTH(WIDTH)
    ) u_detect (
        .clk_i       (clk),
        .clear_n_i   (clear_n),
        .count_i     (count),
        .threshold_i (threshold),
        .wrap_o      (wrap_det),
        .restart_o   (restart_det),
        .hit_o       (hit_det)
    );

    mon_state_e       state_q, state_d;
    logic [2:0]       status_q, status_d;
    logic [TOT_W-1:0] wrap_total_q, wrap_total_d;
    logic             wrap_pulse_q, restart_pulse_q;

    assign event_det = wrap_det | hit_det;

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (event_det) begin
                    state_d  = ST_PENDING;
                    status_d = pack_status(1'b0, hit_det, wrap_det);
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PENDING: begin
                // An event landing on the ack cycle starts a fresh pending episode
                if (irq_ack) begin
                    if (event_det) begin
                        state_d  = ST_PENDING;
                        status_d = pack_status(1'b0, hit_det, wrap_det);
                    end else begin
                        state_d  = enable ? ST_ARMED : ST_IDLE;
                        status_d = '0;
                    end
                end else if (event_det) begin
                    status_d = status_q | pack_status(1'b1, hit_det, wrap_det);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                status_d = '0;
            end
        endcase
    end

    assign wrap_total_d = (wrap_det && (wrap_total_q != '1)) ? wrap_total_q + 1'b1 : wrap_total_q;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q         <= ST_IDLE;
            status_q        <= '0;
            wrap_total_q    <= '0;
            wrap_pulse_q    <= 1'b0;
            restart_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            status_q        <= status_d;
            wrap_total_q    <= wrap_total_d;
            wrap_pulse_q    <= wrap_det;
            restart_pulse_q <= restart_det;
        end
    end

    // Decoded straight from the state register so reset drops it without a clock
    assign irq           = (state_q == ST_PENDING);
    assign status        = status_q;
    assign wrap_total    = wrap_total_q;
    assign wrap_pulse    = wrap_pulse_q;
    assign restart_pulse = restart_pulse_q;

endmodule
